// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM states
//   NIBS_PER_WORD  : hex nibbles assembled into one memory word
//   NIB_W          : nibble width in bits
//   AW_DEF/DW_DEF  : default address / data widths
package mem_loader_pkg;

   localparam int NIBS_PER_WORD = 4;
   localparam int NIB_W         = 4;
   localparam int AW_DEF        = 5;
   localparam int DW_DEF        = NIBS_PER_WORD * NIB_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_VERIFY,
      S_FULL,
      S_ERR
   } loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: single-port instruction memory bus between loader and memory.
//   mem_addr : word address            (master -> slave)
//   mem_data : write data              (master -> slave)
//   mem_wren : write enable            (master -> slave)
//   mem_q    : read data, RD_LAT later (slave  -> master)
interface mem_loader_if
   import mem_loader_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;

   modport master (output mem_addr, output mem_data, output mem_wren, input  mem_q);
   modport slave  (input  mem_addr, input  mem_data, input  mem_wren, output mem_q);
endinterface

// File: rtl/mem_loader_nibble_packer.sv
// nibble_packer: strobe edge detect + nibble shift register for the loader.
//   MClock, Resetn : clock, async active-low reset
//   nib_in         : nibble value, sampled on an accepted strobe edge
//   nib_stb        : strobe level (debounced, synchronous)
//   accept_en      : edges are accepted only while high
//   clear          : discard partial word (wins over accept)
//   asm_q          : assembled word, first nibble ends up as MSN
//   nib_cnt_q      : nibbles collected toward current word
//   word_ready     : accepted edge that completes a word (combinational pulse)
module nibble_packer
   import mem_loader_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic             MClock,
   input  logic             Resetn,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             nib_stb,
   input  logic             accept_en,
   input  logic             clear,
   output logic [DW-1:0]    asm_q,
   output logic [1:0]       nib_cnt_q,
   output logic             word_ready
);

   logic          stb_q;
   logic          accept;
   logic [DW-1:0] asm_d;
   logic [1:0]    nib_cnt_d;

   // stb_q tracks the level every cycle, so a strobe held across a busy
   // period produces no edge once collection resumes.
   assign accept     = accept_en & nib_stb & ~stb_q;
   assign word_ready = accept & (nib_cnt_q == 2'(NIBS_PER_WORD - 1));

   always_comb begin
      asm_d     = asm_q;
      nib_cnt_d = nib_cnt_q;
      if (clear) begin
         asm_d     = '0;
         nib_cnt_d = '0;
      end else if (accept) begin
         asm_d     = {asm_q[DW-NIB_W-1:0], nib_in};
         nib_cnt_d = nib_cnt_q + 2'd1;   // 3 -> 0 wrap on word completion
      end
   end

   always_ff @(posedge MClock or negedge Resetn) begin
      if (!Resetn) begin
         stb_q     <= 1'b0;
         asm_q     <= '0;
         nib_cnt_q <= '0;
      end else begin
         stb_q     <= nib_stb;
         asm_q     <= asm_d;
         nib_cnt_q <= nib_cnt_d;
      end
   end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: keyed-in program loader for the instruction memory.
// Assembles 4 hex nibbles into a word, writes it at the next address, reads it
// back after RD_LAT cycles and counts verified words. Owns the memory port
// only while load_en is high.
//   MClock, Resetn : clock, async active-low reset
//   load_en        : loader enable, low forces IDLE
//   nib_in/nib_stb : nibble value and strobe level
//   mem            : memory bus (master side)
//   word_cnt       : verified words, 0..DEPTH
//   nib_cnt        : nibbles collected toward the current word
//   busy/full/err  : WRITE|VERIFY / FULL / ERR status
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic             MClock,
   input  logic             Resetn,
   input  logic             load_en,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             nib_stb,
   mem_loader_if.master     mem,
   output logic [AW:0]      word_cnt,
   output logic [1:0]       nib_cnt,
   output logic             busy,
   output logic             full,
   output logic             err
);

   localparam int DEPTH = 2 ** AW;
   localparam int VCW   = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

   loader_state_t state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW:0]   word_cnt_q, word_cnt_d;
   logic [VCW-1:0] vcnt_q, vcnt_d;
   logic          mem_wren_q, mem_wren_d;
   logic          busy_q, busy_d;
   logic          full_q, full_d;
   logic          err_q, err_d;

   logic [DW-1:0] asm_q;
   logic          word_ready;

   nibble_packer #(.DW(DW)) u_packer (
      .MClock     (MClock),
      .Resetn     (Resetn),
      .nib_in     (nib_in),
      .nib_stb    (nib_stb),
      .accept_en  (load_en & (state_q == S_COLLECT)),
      .clear      (~load_en | (state_q == S_IDLE)),
      .asm_q      (asm_q),
      .nib_cnt_q  (nib_cnt),
      .word_ready (word_ready)
   );

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      word_cnt_d = word_cnt_q;
      vcnt_d     = vcnt_q;
      if (!load_en) begin
         // address and count stay visible in IDLE until the next load
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d    = S_COLLECT;
               wr_addr_d  = '0;
               word_cnt_d = '0;
            end
            S_COLLECT: if (word_ready) state_d = S_WRITE;
            S_WRITE: begin
               state_d = S_VERIFY;
               vcnt_d  = VCW'(RD_LAT);
            end
            S_VERIFY: begin
               // RD_LAT+1 edges in VERIFY; mem_q is valid on the last one
               if (vcnt_q != '0) begin
                  vcnt_d = vcnt_q - VCW'(1);
               end else if (mem.mem_q == asm_q) begin
                  word_cnt_d = word_cnt_q + (AW+1)'(1);
                  if (wr_addr_q == AW'(DEPTH - 1)) begin
                     state_d = S_FULL;
                  end else begin
                     wr_addr_d = wr_addr_q + AW'(1);
                     state_d   = S_COLLECT;
                  end
               end else begin
                  state_d = S_ERR;
               end
            end
            default: ;   // FULL / ERR are sticky until load_en drops
         endcase
      end
      mem_wren_d = (state_d == S_WRITE);
      busy_d     = (state_d == S_WRITE) || (state_d == S_VERIFY);
      full_d     = (state_d == S_FULL);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge MClock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         wr_addr_q  <= '0;
         word_cnt_q <= '0;
         vcnt_q     <= '0;
         mem_wren_q <= 1'b0;
         busy_q     <= 1'b0;
         full_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         word_cnt_q <= word_cnt_d;
         vcnt_q     <= vcnt_d;
         mem_wren_q <= mem_wren_d;
         busy_q     <= busy_d;
         full_q     <= full_d;
         err_q      <= err_d;
      end
   end

   assign mem.mem_addr = wr_addr_q;
   assign mem.mem_data = asm_q;
   assign mem.mem_wren = mem_wren_q;
   assign word_cnt     = word_cnt_q;
   assign busy         = busy_q;
   assign full         = full_q;
   assign err          = err_q;

endmodule
